sdram_init_seq: RTL and testbench
=================================

# sdram_init_seq

Power-up initialisation sequencer and refresh-interval timer for the board SDRAM, clocked by the PLL's primary SDRAM clock output (33.33 MHz in the current build: 50 MHz in, VCO 800 MHz, /24). After reset it drives the SDRAM command bus through the JEDEC power-up sequence: CKE low wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER. It then hands the bus to the controller via `init_done`, and from then on issues periodic refresh requests with a req/ack handshake.

## Interface
- `POWERUP_CYC`, 6667: cycles CKE is held low after reset (200 µs at 33.33 MHz).
- `T_RP`, 3: PRECHARGE-to-next-command spacing in cycles, ≥1.
- `T_RFC`, 7: REFRESH-to-next-command spacing in cycles, ≥1.
- `T_MRD`, 2: MRS-to-`init_done` spacing in cycles, ≥1.
- `INIT_REFRESH`, 2: AUTO REFRESH commands issued during init, ≥1.
- `MODE_REG`, 13'h030: MRS address value (CAS 3, burst 1, sequential).
- `REFI_CYC`, 260: refresh request period in cycles (7.8 µs).
- `clk`  in  1: SDRAM clock from PLL; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous active-low.
- `cke`  out  1: SDRAM clock enable.
- `cmd`  out  4: {cs_n, ras_n, cas_n, we_n}.
- `addr`  out  13: SDRAM address.
- `ba`  out  2: bank address.
- `init_done`  out  1: sequence complete; controller owns the bus from this cycle.
- `ref_req`  out  1: refresh needed; held until acknowledged.
- `ref_ack`  in  1: controller has taken the request (one-cycle pulse).
- `ref_err`  out  1: sticky flag; a refresh interval expired while `ref_req` was still pending.

## Operation
- Command encodings: INHIBIT 1111, NOP 0111, PRECHARGE 0010, REFRESH 0001, MRS 0000.
- Outputs under reset: `cke`=0, `cmd`=INHIBIT, `addr`=0, `ba`=0, `init_done`=0, `ref_req`=0, `ref_err`=0.
- States:
  - PWRUP: `cke`=0, `cmd`=INHIBIT for POWERUP_CYC cycles.
  - CKE_ON: `cke`=1, NOP, 1 cycle.
  - PRE: PRECHARGE with `addr[10]`=1 and all other addr bits 0, 1 cycle, then NOP for T_RP−1 cycles.
  - REF: REFRESH for 1 cycle, then NOP for T_RFC−1 cycles. Repeats INIT_REFRESH times.
  - MRS: MRS with `addr`=MODE_REG and `ba`=0, 1 cycle, then NOP for T_MRD−1 cycles.
  - DONE: terminal state. `init_done`=1, `cmd`=NOP, `addr`=0, `cke`=1.
- Every non-command cycle after PWRUP drives NOP with `addr`=0.
- Refresh timer runs only in DONE. When it expires: set `ref_req` and restart the count, so the period does not depend on ack latency.
- `ref_ack` while `ref_req`=1 clears `ref_req` on the next edge.
- `ref_ack` while `ref_req`=0 is ignored.
- Expiry and `ref_ack` in the same cycle: `ref_req` stays 1 (the new request wins). `ref_err` is not set.
- Expiry while `ref_req`=1 and no ack in that cycle: set `ref_err`. It stays set until reset.
- Reset mid-sequence: all state returns to PWRUP immediately and the full POWERUP_CYC wait restarts.

## Timing
- Cycle t=0 is the first rising edge that samples `rst_n`=1. All outputs are registered. "At t" means the value after edge t.
- With N=POWERUP_CYC, the `cke` rise and each command occur at these cycles:
  - `cke` rises at t=N.
  - PRE at N+1.
  - REF k (k=0..INIT_REFRESH−1) at N+1+T_RP+k·T_RFC.
  - MRS at N+1+T_RP+INIT_REFRESH·T_RFC.
  - `init_done` at N+1+T_RP+INIT_REFRESH·T_RFC+T_MRD.
- First `ref_req` rises REFI_CYC cycles after `init_done` rises, then every REFI_CYC cycles.
- Counter widths are $clog2 of the largest count they hold. All arithmetic is unsigned. Counters never wrap: they reload on expiry.

## Structure
- Shared header `sdram_defs.vh`: command encodings, `addr[10]` precharge-all bit, MRS field constants. The SDRAM controller uses the same header.
- One sub-module `sdram_refresh_timer`: REFI counter, `ref_req`/`ref_ack` handshake, `ref_err`. Enabled by `init_done`.
- The init FSM plus a single shared delay counter live in the top.

## Test plan
Scenarios 1–4 use POWERUP_CYC=10, T_RP=3, T_RFC=7, T_MRD=2, INIT_REFRESH=2, REFI_CYC=20.
1. Release reset → `cke` rises t=10, PRE with `addr`=0x400 at t=11, REF at t=14 and t=21, MRS with `addr`=0x030 at t=28, `init_done` at t=30. NOP in every other cycle from t=10.
2. After `init_done`, ack each `ref_req` 3 cycles after it rises → `ref_req` rises at t=50, 70, 90; it is high for exactly 4 cycles each time; `ref_err` stays 0.
3. Never ack → `ref_req` rises at t=50 and stays high; `ref_err` sets at t=70.
4. Ack in the exact cycle of the next expiry → `ref_req` stays 1; `ref_err` stays 0.
5. Assert `rst_n`=0 during the REF phase → all outputs return to reset values asynchronously. After release, the full sequence repeats from scenario 1 timing.
6. Default parameters → `init_done` at t=6667+1+3+14+2=6687; first `ref_req` at t=6947.

Source files
------------

// File: rtl/sdram_init_seq_pkg.sv
// Shared SDRAM definitions: command encodings, precharge-all address bit,
// mode-register field values and the init sequencer's state type.
package sdram_init_seq_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    localparam int ADDR_PRECHARGE_ALL_BIT = 10;

    localparam logic [2:0] MRS_CAS_2  = 3'd2;
    localparam logic [2:0] MRS_CAS_3  = 3'd3;
    localparam logic       MRS_BT_SEQ = 1'b0;
    localparam logic       MRS_BT_INT = 1'b1;
    localparam logic [2:0] MRS_BL_1   = 3'd0;
    localparam logic [2:0] MRS_BL_2   = 3'd1;
    localparam logic [2:0] MRS_BL_4   = 3'd2;
    localparam logic [2:0] MRS_BL_8   = 3'd3;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_CKE_ON,
        ST_PRE,
        ST_REF,
        ST_MRS,
        ST_DONE
    } init_state_e;

    // Mode word layout: A9 write-burst mode, A8:7 op mode, A6:4 CAS, A3 BT, A2:0 BL
    function automatic logic [12:0] mode_word(input logic [2:0] cas,
                                              input logic       bt,
                                              input logic [2:0] bl);
        return {3'b000, 1'b0, 2'b00, cas, bt, bl};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator with req/ack handshake and a sticky
// overrun flag for a request left pending across a whole interval.
module sdram_refresh_timer
    import sdram_init_seq_pkg::*;
#(
    parameter int REFI_CYC = 260
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_err
);

    localparam int CNT_W = max_int(1, $clog2(REFI_CYC));
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFI_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             req_reg;
    logic             err_reg;
    logic             expire;

    assign expire = en && (cnt_reg == '0);

    // Reload on expiry so the period is independent of the ack latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= CNT_RELOAD;
            req_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if (en) begin
                cnt_reg <= expire ? CNT_RELOAD : cnt_reg - 1'b1;
            end
            if (expire) begin
                req_reg <= 1'b1;
                if (req_reg && !ref_ack) begin
                    err_reg <= 1'b1;
                end
            end else if (ref_ack && req_reg) begin
                req_reg <= 1'b0;
            end
        end
    end

    assign ref_req = req_reg;
    assign ref_err = err_reg;

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer (CKE wait, PRECHARGE ALL, AUTO REFRESH x N, MRS)
// followed by the periodic refresh request timer.
module sdram_init_seq
    import sdram_init_seq_pkg::*;
#(
    parameter int          POWERUP_CYC  = 6667,
    parameter int          T_RP         = 3,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          INIT_REFRESH = 2,
    parameter logic [12:0] MODE_REG     = mode_word(MRS_CAS_3, MRS_BT_SEQ, MRS_BL_1),
    parameter int          REFI_CYC     = 260
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cke,
    output logic [3:0]  cmd,
    output logic [12:0] addr,
    output logic [1:0]  ba,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_err
);

    localparam int DLY_MAX = max_int(POWERUP_CYC,
                             max_int(T_RP - 1, max_int(T_RFC - 1, T_MRD - 1)));
    localparam int DLY_W   = max_int(1, $clog2(DLY_MAX + 1));
    localparam int REF_W   = max_int(1, $clog2(INIT_REFRESH));

    localparam logic [DLY_W-1:0] DLY_PWRUP = DLY_W'(POWERUP_CYC);
    localparam logic [DLY_W-1:0] DLY_RP    = DLY_W'(T_RP - 1);
    localparam logic [DLY_W-1:0] DLY_RFC   = DLY_W'(T_RFC - 1);
    localparam logic [DLY_W-1:0] DLY_MRD   = DLY_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(INIT_REFRESH - 1);

    init_state_e       state_reg, state_next;
    logic [DLY_W-1:0]  dly_reg, dly_next;
    logic [REF_W-1:0]  ref_left_reg, ref_left_next;
    logic              cke_reg, cke_next;
    logic [3:0]        cmd_reg, cmd_next;
    logic [12:0]       addr_reg, addr_next;
    logic              done_reg, done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_PWRUP;
            dly_reg      <= DLY_PWRUP;
            ref_left_reg <= '0;
            cke_reg      <= 1'b0;
            cmd_reg      <= CMD_INHIBIT;
            addr_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dly_reg      <= dly_next;
            ref_left_reg <= ref_left_next;
            cke_reg      <= cke_next;
            cmd_reg      <= cmd_next;
            addr_reg     <= addr_next;
            done_reg     <= done_next;
        end
    end

    // Outputs are decoded for the cycle being entered, then registered.
    // The shared delay counter is loaded with (spacing-1) when a command issues
    // and the phase advances on the edge where it reads zero.
    always_comb begin
        state_next    = state_reg;
        dly_next      = dly_reg;
        ref_left_next = ref_left_reg;
        cke_next      = 1'b1;
        cmd_next      = CMD_NOP;
        addr_next     = '0;
        done_next     = 1'b0;

        case (state_reg)
            ST_PWRUP: begin
                if (dly_reg == '0) begin
                    state_next = ST_CKE_ON;
                end else begin
                    dly_next = dly_reg - 1'b1;
                    cke_next = 1'b0;
                    cmd_next = CMD_INHIBIT;
                end
            end
            ST_CKE_ON: begin
                state_next = ST_PRE;
                cmd_next   = CMD_PRECHARGE;
                addr_next[ADDR_PRECHARGE_ALL_BIT] = 1'b1;
                dly_next   = DLY_RP;
            end
            ST_PRE: begin
                if (dly_reg == '0) begin
                    state_next    = ST_REF;
                    cmd_next      = CMD_REFRESH;
                    dly_next      = DLY_RFC;
                    ref_left_next = REF_LAST;
                end else begin
                    dly_next = dly_reg - 1'b1;
                end
            end
            ST_REF: begin
                if (dly_reg != '0) begin
                    dly_next = dly_reg - 1'b1;
                end else if (ref_left_reg == '0) begin
                    state_next = ST_MRS;
                    cmd_next   = CMD_MRS;
                    addr_next  = MODE_REG;
                    dly_next   = DLY_MRD;
                end else begin
                    cmd_next      = CMD_REFRESH;
                    dly_next      = DLY_RFC;
                    ref_left_next = ref_left_reg - 1'b1;
                end
            end
            ST_MRS: begin
                if (dly_reg == '0) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    dly_next = dly_reg - 1'b1;
                end
            end
            ST_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = ST_PWRUP;
                dly_next   = DLY_PWRUP;
                cke_next   = 1'b0;
                cmd_next   = CMD_INHIBIT;
            end
        endcase
    end

    assign cke       = cke_reg;
    assign cmd       = cmd_reg;
    assign addr      = addr_reg;
    assign ba        = 2'b00;
    assign init_done = done_reg;

    sdram_refresh_timer #(
        .REFI_CYC (REFI_CYC)
    ) u_refresh_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (done_reg),
        .ref_ack (ref_ack),
        .ref_req (ref_req),
        .ref_err (ref_err)
    );

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: small-parameter instance for sequence/refresh
// scenarios and a default-parameter instance for the full-length timing.
module tb_sdram_init_seq;

    localparam int N     = 10;
    localparam int TRP   = 3;
    localparam int TRFC  = 7;
    localparam int TMRD  = 2;
    localparam int NREF  = 2;
    localparam int REFI  = 20;
    localparam int DONE_T = N + 1 + TRP + NREF * TRFC + TMRD;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_ack = 1'b0;
    logic        cke, init_done, ref_req, ref_err;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;

    logic        rst_n_b = 1'b0;
    logic        ref_ack_b = 1'b0;
    logic        cke_b, init_done_b, ref_req_b, ref_err_b;
    logic [3:0]  cmd_b;
    logic [12:0] addr_b;
    logic [1:0]  ba_b;

    always #5 clk = ~clk;

    sdram_init_seq #(
        .POWERUP_CYC (N), .T_RP (TRP), .T_RFC (TRFC), .T_MRD (TMRD),
        .INIT_REFRESH (NREF), .MODE_REG (13'h030), .REFI_CYC (REFI)
    ) dut (
        .clk (clk), .rst_n (rst_n), .cke (cke), .cmd (cmd), .addr (addr),
        .ba (ba), .init_done (init_done), .ref_req (ref_req),
        .ref_ack (ref_ack), .ref_err (ref_err)
    );

    sdram_init_seq dut_def (
        .clk (clk), .rst_n (rst_n_b), .cke (cke_b), .cmd (cmd_b), .addr (addr_b),
        .ba (ba_b), .init_done (init_done_b), .ref_req (ref_req_b),
        .ref_ack (ref_ack_b), .ref_err (ref_err_b)
    );

    int   n_checks = 0;
    int   n_err = 0;
    int   t = -1;
    logic m_req, m_err;

    typedef struct {
        int          t;
        logic [20:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [20:0] obs [0:63];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    function automatic logic [20:0] pack(input logic c, input logic [3:0] k,
                                         input logic [12:0] a, input logic d);
        return {c, k, a, 2'b00, d};
    endfunction

    // Expected bus at cycle t, straight from the command schedule.
    function automatic logic [20:0] exp_init(input int tt);
        if (tt < N)                        return pack(1'b0, C_INH, 13'h000, 1'b0);
        if (tt >= DONE_T)                  return pack(1'b1, C_NOP, 13'h000, 1'b1);
        if (tt == N + 1)                   return pack(1'b1, C_PRE, 13'h400, 1'b0);
        for (int k = 0; k < NREF; k++)
            if (tt == N + 1 + TRP + k * TRFC) return pack(1'b1, C_REF, 13'h000, 1'b0);
        if (tt == DONE_T - TMRD)           return pack(1'b1, C_MRS, 13'h030, 1'b0);
        return pack(1'b1, C_NOP, 13'h000, 1'b0);
    endfunction

    function automatic logic [20:0] bus();
        return {cke, cmd, addr, ba, init_done};
    endfunction

    task automatic cyc(input logic a);
        logic expire;
        ref_ack = a;
        @(posedge clk);
        #1;
        t++;
        expire = (t > DONE_T) && (((t - DONE_T) % REFI) == 0);
        if (expire) begin
            if (m_req && !a) m_err = 1'b1;
            m_req = 1'b1;
        end else if (a && m_req) begin
            m_req = 1'b0;
        end
        if (t < 64) obs[t] = bus();
        chk("seq", 32'(bus()), 32'(exp_init(t)));
        chk("refresh", {30'd0, ref_req, ref_err}, {30'd0, m_req, m_err});
    endtask

    task automatic release_reset();
        rst_n   = 1'b0;
        ref_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", {9'd0, bus(), ref_req, ref_err},
            {9'd0, pack(1'b0, C_INH, 13'h000, 1'b0), 2'b00});
        rst_n = 1'b1;
        t     = -1;
        m_req = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin
        int rises[$];
        int lens[$];
        int rise_t;
        int hi_len;
        logic prev;

        vecs[0] = '{9,  pack(1'b0, C_INH, 13'h000, 1'b0)};
        vecs[1] = '{10, pack(1'b1, C_NOP, 13'h000, 1'b0)};
        vecs[2] = '{11, pack(1'b1, C_PRE, 13'h400, 1'b0)};
        vecs[3] = '{14, pack(1'b1, C_REF, 13'h000, 1'b0)};
        vecs[4] = '{21, pack(1'b1, C_REF, 13'h000, 1'b0)};
        vecs[5] = '{28, pack(1'b1, C_MRS, 13'h030, 1'b0)};
        vecs[6] = '{29, pack(1'b1, C_NOP, 13'h000, 1'b0)};
        vecs[7] = '{30, pack(1'b1, C_NOP, 13'h000, 1'b1)};

        // Scenario 1 and 2: sequence, then ack each request 3 cycles after rise.
        release_reset();
        rise_t = -100;
        hi_len = 0;
        prev   = 1'b0;
        while (t < 95) begin
            cyc((rises.size() > 0) && (t == rise_t + 3));
            if (ref_req && !prev) begin
                rise_t = t;
                rises.push_back(t);
                hi_len = 0;
            end
            if (ref_req) hi_len++;
            if (!ref_req && prev) lens.push_back(hi_len);
            prev = ref_req;
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("vec_t%0d", vecs[i].t), 32'(obs[vecs[i].t]), 32'(vecs[i].exp));
        chk("rise_count", rises.size(), 3);
        chk("len_count", lens.size(), 3);
        for (int i = 0; i < 3 && i < rises.size(); i++)
            chk($sformatf("rise%0d", i), rises[i], 50 + 20 * i);
        for (int i = 0; i < 3 && i < lens.size(); i++)
            chk($sformatf("len%0d", i), lens[i], 4);
        chk("err_after_acks", {31'd0, ref_err}, 0);

        // Scenario 3: never acknowledge.
        release_reset();
        while (t < 49) cyc(1'b0);
        chk("noack_req49", {31'd0, ref_req}, 0);
        while (t < 69) cyc(1'b0);
        chk("noack_req69", {31'd0, ref_req}, 1);
        chk("noack_err69", {31'd0, ref_err}, 0);
        cyc(1'b0);
        chk("noack_err70", {31'd0, ref_err}, 1);
        while (t < 80) cyc(1'b0);
        chk("noack_err80", {31'd0, ref_err}, 1);

        // Scenario 4: ack lands on the expiry edge.
        release_reset();
        while (t < 80) cyc(t + 1 == 70);
        chk("coinc_req", {31'd0, ref_req}, 1);
        chk("coinc_err", {31'd0, ref_err}, 0);

        // Randomized acks, including during init where they must be ignored.
        release_reset();
        while (t < 300) cyc($urandom_range(0, 2) == 0);

        // Scenario 5: asynchronous reset in the REF phase, then full rerun.
        release_reset();
        while (t < 17) cyc(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {9'd0, bus(), ref_req, ref_err},
            {9'd0, pack(1'b0, C_INH, 13'h000, 1'b0), 2'b00});
        release_reset();
        while (t < 55) cyc(1'b0);
        chk("rerun_done", {31'd0, init_done}, 1);

        // Scenario 6: default parameters.
        rst_n_b = 1'b0;
        @(posedge clk);
        #2;
        rst_n_b = 1'b1;
        for (int tb = 0; tb <= 6950; tb++) begin
            @(posedge clk);
            #1;
            if (tb == 6666) chk("def_cke_6666", {31'd0, cke_b}, 0);
            if (tb == 6667) chk("def_cke_6667", {31'd0, cke_b}, 1);
            if (tb == 6686) chk("def_done_6686", {31'd0, init_done_b}, 0);
            if (tb == 6687) chk("def_done_6687", {31'd0, init_done_b}, 1);
            if (tb == 6946) chk("def_req_6946", {31'd0, ref_req_b}, 0);
            if (tb == 6947) chk("def_req_6947", {31'd0, ref_req_b}, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
